uart_tx_fifo: RTL and testbench

//  Byte FIFO and launch sequencer that sits directly upstream of the UART transmitter.
//  - Accepts bytes from a producer with a valid/ready handshake.
//  - Holds one byte stable on tx_data for a whole frame.
//  - Starts each frame with a one-cycle high pulse on tx_send; the transmitter triggers on the falling edge.
//  - Watches tx_sending to know when the frame is finished.

---
 rtl/uart_tx_fifo_if.sv | 21 ++
 rtl/uart_tx_fifo.sv | 130 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Producer and transmitter signals of the UART TX FIFO, bundled for port connection.
// Write side: a byte moves on any posedge where wr_valid && wr_ready; wr_data must be stable while wr_valid=1.
interface uart_tx_fifo_if;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_sending;

  // master: producer plus transmitter environment; slave: the FIFO itself
  modport master (
    output wr_data, wr_valid, tx_sending,
    input  wr_ready, tx_data, tx_send
  );

  modport slave (
    input  wr_data, wr_valid, tx_sending,
    output wr_ready, tx_data, tx_send
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO and frame launch sequencer feeding a UART transmitter.
// Optional sticky overflow flag (ovf port) is built when UART_TX_FIFO_OVF_EN is defined.
module uart_tx_fifo #(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_tx_fifo_if.slave          bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
`ifdef UART_TX_FIFO_OVF_EN
  output logic                   ovf,
`endif
  output logic [1:0]             state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_WAIT = 2'd2,
    S_BUSY = 2'd3
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    gap;
  logic [1:0]    wait_cnt;
  logic          wr_fire;
  logic          pop;
  logic          timeout;

  assign empty         = (count == '0);
  assign full          = (count == CW'(DEPTH));
  assign bus.wr_ready  = !full;
  assign state_dbg     = state;

  // Refusal while full ignores a same-cycle pop, keeping wr_ready a pure function of count.
  assign wr_fire = bus.wr_valid && !full;
  assign pop     = (state == S_IDLE) && !empty && !bus.tx_sending && (gap == 8'd0);
  assign timeout = (state == S_WAIT) && !bus.tx_sending && (wait_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_fire, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // tx_data is only ever loaded on a pop so the transmitter can sample it live all frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      bus.tx_data <= 8'h00;
      bus.tx_send <= 1'b0;
      gap         <= 8'd0;
      wait_cnt    <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.tx_send <= 1'b0;
          if (pop) begin
            bus.tx_data <= mem[rd_ptr];
            bus.tx_send <= 1'b1;
            state       <= S_ARM;
          end else if (gap != 8'd0) begin
            gap <= gap - 8'd1;
          end
        end
        S_ARM: begin
          bus.tx_send <= 1'b0;
          wait_cnt    <= 2'd0;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.tx_sending) begin
            state <= S_BUSY;
          end else if (timeout) begin
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        S_BUSY: begin
          if (!bus.tx_sending) begin
            gap   <= 8'(GAP_CYCLES);
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if ((bus.wr_valid && full) || timeout) begin
      ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: instance d0 has GAP_CYCLES=0, instance d1 has GAP_CYCLES=10.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_BUSY = 2'd3;

  logic       clk;
  logic       rst;
  logic [4:0] count0, count1;
  logic       empty0, empty1, full0, full1;
  logic [1:0] state0, state1;
`ifdef UART_TX_FIFO_OVF_EN
  logic       ovf0, ovf1;
`endif
  int         tests;
  int         fails;
  logic [7:0] exp_q[$];

  uart_tx_fifo_if b0();
  uart_tx_fifo_if b1();

  uart_tx_fifo #(.DEPTH(16), .GAP_CYCLES(0)) d0 (
    .clk(clk), .rst(rst), .bus(b0), .count(count0), .empty(empty0), .full(full0),
`ifdef UART_TX_FIFO_OVF_EN
    .ovf(ovf0),
`endif
    .state_dbg(state0)
  );

  uart_tx_fifo #(.DEPTH(16), .GAP_CYCLES(10)) d1 (
    .clk(clk), .rst(rst), .bus(b1), .count(count1), .empty(empty1), .full(full1),
`ifdef UART_TX_FIFO_OVF_EN
    .ovf(ovf1),
`endif
    .state_dbg(state1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write0(input logic [7:0] d);
    b0.wr_data  = d;
    b0.wr_valid = 1'b1;
    tick();
    b0.wr_valid = 1'b0;
  endtask

  task automatic write1(input logic [7:0] d);
    b1.wr_data  = d;
    b1.wr_valid = 1'b1;
    tick();
    b1.wr_valid = 1'b0;
  endtask

  // Plays the transmitter on d0 for one frame: waits (bounded) for tx_send, then a short busy period.
  task automatic serve0(output logic got, output logic [7:0] data);
    got  = 1'b0;
    data = 8'h00;
    for (int i = 0; i < 30; i++) begin
      if (b0.tx_send === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    if (!got) return;
    data = b0.tx_data;
    tick();
    tick();
    b0.tx_sending = 1'b1;
    repeat (3) tick();
    b0.tx_sending = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic seen;
    tests++; if (count0 !== 5'd0) begin fails++; $display("FAIL rst_count got=%0d exp=0", count0); end
    tests++; if (empty0 !== 1'b1 || full0 !== 1'b0) begin fails++; $display("FAIL rst_flags empty=%b full=%b exp empty=1 full=0", empty0, full0); end
    tests++; if (b0.wr_ready !== 1'b1) begin fails++; $display("FAIL rst_wr_ready got=%b exp=1", b0.wr_ready); end
    tests++; if (b0.tx_send !== 1'b0 || b0.tx_data !== 8'h00) begin fails++; $display("FAIL rst_tx send=%b data=%h exp 0/00", b0.tx_send, b0.tx_data); end
`ifdef UART_TX_FIFO_OVF_EN
    tests++; if (ovf0 !== 1'b0) begin fails++; $display("FAIL rst_ovf got=%b exp=0", ovf0); end
`endif
    rst = 1'b0;
    write0(8'h5A);
    write0(8'h6B);
    // now after the pop of 5A: assert reset asynchronously mid-cycle
    #2;
    rst = 1'b1;
    #1;
    tests++; if (b0.tx_send !== 1'b0 || b0.tx_data !== 8'h00) begin fails++; $display("FAIL async_rst_tx send=%b data=%h exp 0/00", b0.tx_send, b0.tx_data); end
    tests++; if (count0 !== 5'd0 || empty0 !== 1'b1 || b0.wr_ready !== 1'b1) begin fails++; $display("FAIL async_rst_fifo count=%0d empty=%b ready=%b exp 0/1/1", count0, empty0, b0.wr_ready); end
    tests++; if (state0 !== S_IDLE) begin fails++; $display("FAIL async_rst_state got=%0d exp=%0d", state0, S_IDLE); end
    // release while a frame is still in flight
    b0.tx_sending = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    write0(8'h3C);
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (b0.tx_send !== 1'b0) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0 || count0 !== 5'd1) begin fails++; $display("FAIL no_pop_while_sending seen_send=%b count=%0d exp 0/1", seen, count0); end
    b0.tx_sending = 1'b0;
    tick();
    tests++; if (b0.tx_send !== 1'b1 || b0.tx_data !== 8'h3C) begin fails++; $display("FAIL launch_after_frame send=%b data=%h exp 1/3c", b0.tx_send, b0.tx_data); end
    tick();
    b0.tx_sending = 1'b1;
    tick();
    tick();
    b0.tx_sending = 1'b0;
    tick();
    tests++; if (state0 !== S_IDLE || count0 !== 5'd0) begin fails++; $display("FAIL rst_end state=%0d count=%0d exp 0/0", state0, count0); end
  endtask

  task automatic test_single();
    logic bad;
    write0(8'hA5);
    tests++; if (b0.tx_send !== 1'b0 || count0 !== 5'd1) begin fails++; $display("FAIL single_k send=%b count=%0d exp 0/1", b0.tx_send, count0); end
    tick();
    tests++; if (b0.tx_send !== 1'b1 || b0.tx_data !== 8'hA5 || count0 !== 5'd0) begin fails++; $display("FAIL single_k1 send=%b data=%h count=%0d exp 1/a5/0", b0.tx_send, b0.tx_data, count0); end
    tests++; if (state0 !== S_ARM) begin fails++; $display("FAIL single_arm state=%0d exp=%0d", state0, S_ARM); end
    tick();
    tests++; if (b0.tx_send !== 1'b0 || state0 !== S_WAIT) begin fails++; $display("FAIL single_k2 send=%b state=%0d exp 0/%0d", b0.tx_send, state0, S_WAIT); end
    tick();
    b0.tx_sending = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (b0.tx_data !== 8'hA5 || b0.tx_send !== 1'b0 || state0 !== S_BUSY) bad = 1'b1;
    end
    tests++; if (bad !== 1'b0) begin fails++; $display("FAIL single_hold data=%h send=%b state=%0d exp a5/0/%0d", b0.tx_data, b0.tx_send, state0, S_BUSY); end
    b0.tx_sending = 1'b0;
    tick();
    tick();
    tests++; if (state0 !== S_IDLE || count0 !== 5'd0 || b0.tx_send !== 1'b0 || b0.tx_data !== 8'hA5) begin fails++; $display("FAIL single_end state=%0d count=%0d send=%b data=%h exp 0/0/0/a5", state0, count0, b0.tx_send, b0.tx_data); end
`ifdef UART_TX_FIFO_OVF_EN
    tests++; if (ovf0 !== 1'b0) begin fails++; $display("FAIL single_ovf got=%b exp=0", ovf0); end
`endif
  endtask

  task automatic test_timeout();
    logic bad;
    b0.tx_sending = 1'b0;
    write0(8'h77);
    tick();
    tick();
    tests++; if (state0 !== S_WAIT) begin fails++; $display("FAIL timeout_entry state=%0d exp=%0d", state0, S_WAIT); end
    bad = 1'b0;
    repeat (3) begin
      tick();
      if (state0 !== S_WAIT) bad = 1'b1;
    end
    tests++; if (bad !== 1'b0) begin fails++; $display("FAIL timeout_early state=%0d exp=%0d", state0, S_WAIT); end
    tick();
    tests++; if (state0 !== S_IDLE || count0 !== 5'd0 || b0.tx_data !== 8'h77) begin fails++; $display("FAIL timeout_return state=%0d count=%0d data=%h exp 0/0/77", state0, count0, b0.tx_data); end
`ifdef UART_TX_FIFO_OVF_EN
    tests++; if (ovf0 !== 1'b1) begin fails++; $display("FAIL timeout_ovf got=%b exp=1", ovf0); end
`endif
    tick();
    tests++; if (b0.tx_send !== 1'b0) begin fails++; $display("FAIL timeout_no_relaunch got=%b exp=0", b0.tx_send); end
  endtask

  task automatic test_fill();
    logic       got;
    logic [7:0] data;
    b0.tx_sending = 1'b1;
    b0.wr_valid   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b0.wr_data = 8'(i);
      tick();
    end
    b0.wr_data = 8'hEE;
    tick();
    tests++; if (count0 !== 5'd16 || full0 !== 1'b1 || b0.wr_ready !== 1'b0) begin fails++; $display("FAIL fill_full count=%0d full=%b ready=%b exp 16/1/0", count0, full0, b0.wr_ready); end
`ifdef UART_TX_FIFO_OVF_EN
    tests++; if (ovf0 !== 1'b1) begin fails++; $display("FAIL fill_ovf got=%b exp=1", ovf0); end
`endif
    // the refused write stays pending across the first pop
    b0.tx_sending = 1'b0;
    tick();
    tests++; if (count0 !== 5'd15 || b0.tx_send !== 1'b1 || b0.tx_data !== 8'h00) begin fails++; $display("FAIL fill_pop_refuse count=%0d send=%b data=%h exp 15/1/00", count0, b0.tx_send, b0.tx_data); end
    b0.wr_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      serve0(got, data);
      tests++; if (got !== 1'b1 || data !== 8'(i)) begin fails++; $display("FAIL fill_order idx=%0d got_send=%b data=%h exp 1/%h", i, got, data, 8'(i)); end
    end
    tick();
    tests++; if (count0 !== 5'd0 || empty0 !== 1'b1 || b0.tx_send !== 1'b0) begin fails++; $display("FAIL fill_drained count=%0d empty=%b send=%b exp 0/1/0", count0, empty0, b0.tx_send); end
  endtask

  task automatic test_simultaneous();
    logic       got;
    logic [7:0] data;
    logic [7:0] exp;
    exp_q.delete();
    b0.tx_sending = 1'b1;
    for (int i = 0; i < 5; i++) begin
      write0(8'h80 + 8'(i));
      exp_q.push_back(8'h80 + 8'(i));
    end
    tests++; if (count0 !== 5'd5) begin fails++; $display("FAIL simul_pre count=%0d exp=5", count0); end
    b0.wr_data    = 8'h85;
    b0.wr_valid   = 1'b1;
    b0.tx_sending = 1'b0;
    exp_q.push_back(8'h85);
    tick();
    b0.wr_valid = 1'b0;
    tests++; if (count0 !== 5'd5 || b0.tx_send !== 1'b1 || b0.tx_data !== 8'h80) begin fails++; $display("FAIL simul_edge count=%0d send=%b data=%h exp 5/1/80", count0, b0.tx_send, b0.tx_data); end
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      serve0(got, data);
      tests++; if (got !== 1'b1 || data !== exp) begin fails++; $display("FAIL simul_order got_send=%b data=%h exp 1/%h", got, data, exp); end
    end
    // 40 bytes in batches of 10 walk both pointers around the ring several times
    for (int b = 0; b < 4; b++) begin
      b0.tx_sending = 1'b1;
      for (int i = 0; i < 10; i++) begin
        write0(8'h40 + 8'(b * 10 + i));
        exp_q.push_back(8'h40 + 8'(b * 10 + i));
      end
      b0.tx_sending = 1'b0;
      while (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        serve0(got, data);
        tests++; if (got !== 1'b1 || data !== exp) begin fails++; $display("FAIL wrap_order batch=%0d got_send=%b data=%h exp 1/%h", b, got, data, exp); end
      end
    end
    tests++; if (count0 !== 5'd0 || empty0 !== 1'b1) begin fails++; $display("FAIL wrap_drained count=%0d empty=%b exp 0/1", count0, empty0); end
  endtask

  task automatic test_gap();
    int rise;
    int highs;
    b1.tx_sending = 1'b1;
    write1(8'h11);
    write1(8'h22);
    b1.tx_sending = 1'b0;
    tick();
    tests++; if (b1.tx_send !== 1'b1 || b1.tx_data !== 8'h11) begin fails++; $display("FAIL gap_first send=%b data=%h exp 1/11", b1.tx_send, b1.tx_data); end
    tick();
    tick();
    b1.tx_sending = 1'b1;
    repeat (3) tick();
    b1.tx_sending = 1'b0;
    rise  = 0;
    highs = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (b1.tx_send === 1'b1) begin
        highs++;
        if (rise == 0) begin
          rise = n;
          tests++; if (b1.tx_data !== 8'h22) begin fails++; $display("FAIL gap_second_data got=%h exp=22", b1.tx_data); end
        end
      end
    end
    tests++; if (rise != 12) begin fails++; $display("FAIL gap_timing rise_cycle=%0d exp=12", rise); end
    tests++; if (highs != 1) begin fails++; $display("FAIL gap_pulse_width high_cycles=%0d exp=1", highs); end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst           = 1'b1;
    b0.wr_data    = 8'h00;
    b0.wr_valid   = 1'b0;
    b0.tx_sending = 1'b0;
    b1.wr_data    = 8'h00;
    b1.wr_valid   = 1'b0;
    b1.tx_sending = 1'b0;
    repeat (3) tick();
    test_reset();
    test_single();
    test_timeout();
    test_fill();
    test_simultaneous();
    test_gap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
